instruction_decoder: RTL and testbench
======================================

# instruction_decoder

Byte-serial x86/V30 instruction decoder between the prefetch queue and the microsequencer. Consumes one instruction byte per cycle from the queue and collects prefixes, opcode, ModRM, displacement and immediates. It then presents one fully decoded instruction to the microsequencer under a valid/ready handshake. A flush input discards partial decode on control-flow change.

## Interface
- No parameters.
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-low.
- `flush` in 1: synchronous discard of partial or pending decode.
- `fetch_data` in 8: next instruction byte from the prefetch queue.
- `fetch_valid` in 1: `fetch_data` holds a byte.
- `fetch_ready` out 1: the byte is consumed this cycle when `fetch_valid & fetch_ready`.
- `decode_valid` out 1: all decode outputs are stable and complete.
- `decode_ready` in 1: the microsequencer accepts the instruction.
- `opcode` out 8, `mod` out 2, `rm` out 3, `reg` out 3: instruction fields.
- `src`, `dst` out 4 each: register indices. 0–7 select AX..DI; 8–15 select AL..BH.
- `disp` out 16: displacement, sign-extended.
- `imm` out 16: first immediate.
- `imm_size` out 1: 1 means 16-bit.
- `imm2` out 16: second immediate (far segment or ENTER level).
- `seg_override` out 3: bit 2 = valid, bits 1:0 = ES/CS/SS/DS.
- `rep` out 2: 00 none, 10 F2, 11 F3.
- `lock` out 1: lock prefix seen.
- `length` out 4: instruction length in bytes, saturating at 15.

## Operation
- States: OPCODE, MODRM, DISP_LO, DISP_HI, IMM_LO, IMM_HI, IMM2_LO, IMM2_HI, VALID.
- `fetch_ready` = 1 in every state except VALID.
- OPCODE handles prefix and opcode bytes:
  - Prefix bytes are 26/2E/36/3E, F0, F2, F3. Record them and stay in OPCODE.
  - A later segment or rep prefix overwrites an earlier one.
  - Any other byte is latched as `opcode`. Next state is MODRM if the opcode has a ModRM byte, otherwise the first needed operand state, otherwise VALID.
- ModRM opcodes: 00–3F with `op[7:6]=00 & op[2]=0`; 62, 63, 69, 6B; 80–8F; C0, C1, C4–C7; D0–D3; D8–DF; F6, F7, FE, FF.
- Displacement length:
  - mod 01: 1 byte, sign-extended.
  - mod 10: 2 bytes.
  - mod 00 with rm 110: 2 bytes.
  - A0–A3: 2 bytes, no ModRM.
  - Otherwise none.
- Immediate length in bytes:
  - 1 byte: `op[2:0]=4` in the 00–3F ALU group; 6A, 6B, 80, 82, 83, A8, B0–B7, C0, C1, C6, CD, E4–E7, EB, 70–7F, E0–E3.
  - 1 byte: F6 when reg=000.
  - 2 bytes: `op[2:0]=5` in the 00–3F ALU group; 68, 69, 81, A9, B8–BF, C2, CA, C7, E8, E9.
  - 2 bytes: F7 when reg=000.
  - imm 2 + imm2 2: 9A, EA.
  - imm 2 + imm2 1: C8.
- One-byte `imm` is sign-extended for 6A, 6B, 83, 70–7F, E0–E3, EB; zero-extended otherwise.
- `imm_size` = 1 exactly when `imm` came from 2 bytes.
- Register indices, with w = `op[0]`:
  - 00–3F ALU group and 84–8B: d = `op[1]`. d=1 gives `dst={~w,reg}`, `src={~w,rm}`. d=0 swaps them.
  - Other ModRM opcodes: `src={~w,reg}`, `dst={~w,rm}`.
  - B0–BF: `dst={~op[3],op[2:0]}`.
  - 40–5F: `dst=src={0,op[2:0]}`.
  - Otherwise 0.
- Fields that an instruction does not use read 0.
- VALID: hold all outputs. On `decode_ready`, clear prefixes and `length`, then go to OPCODE.
- `flush` has priority over everything else, including `fetch_valid` and `decode_ready`. Next cycle: state OPCODE, `decode_valid`=0, prefixes cleared, and no byte is consumed that cycle.

## Timing
- Each accepted byte advances exactly one state. When `fetch_valid` is 0, the decoder stalls with no state change.
- `decode_valid` rises in the cycle after the last byte is accepted. An N-byte instruction reaches VALID N cycles after its first accepted byte, with no bubbles.
- Handoff costs 1 cycle: the first byte of the next instruction is accepted no earlier than the cycle after `decode_valid & decode_ready`.
- Reset values: state OPCODE, `fetch_ready`=1 (0 while `reset` is asserted), `decode_valid`=0, and every other output 0.
- Deasserting `reset` mid-instruction loses the instruction.

## Structure
- Shared package `v30_decode_pkg`:
  - state enum
  - register index encoding
  - prefix byte constants
  - functions `has_modrm(op)`, `imm_bytes(op, reg)`, `imm_sext(op)`
- One sub-module, `opcode_attributes`: a combinational table mapping opcode to {has_modrm, imm class, d/w usage}. It is later shared with the microcode translation ROM generation.

## Test plan
- 8B 80 34 12 → opcode 8B, mod 10, rm 000, reg 000, dst 0, src 0, disp 1234, length 4, `decode_valid` 4 cycles after first byte.
- 2E F3 A4 → `seg_override` 101, `rep` 11, opcode A4, length 3, no ModRM.
- 83 46 FE 05 → mod 01, rm 110, disp FFFE, imm 0005, `imm_size` 0; then 81 C3 34 12 → imm 1234, `imm_size` 1, dst 3.
- F6 06 34 12 AA → disp 1234, imm 00AA, length 5; F6 16 34 12 (reg 010) → length 4, no immediate.
- EA 00 01 00 F0 with `fetch_valid` toggled every other cycle → imm 0100, imm2 F000, length 5; `decode_valid` held until `decode_ready` pulse.
- `flush` asserted after C7 06 → next cycle in OPCODE with prefixes clear; following B8 34 12 decodes cleanly to dst 0, imm 1234.

Source files
------------

// File: rtl/v30_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module   : v30_decode_pkg
// Brief    : Shared decode types, constants and opcode classification helpers
//            for the byte-serial x86/V30 instruction decoder.
// Revision : 1.0 - initial release
// ============================================================================
package v30_decode_pkg;

  // Decoder sequencing states
  typedef enum logic [3:0] {
    ST_OPCODE  = 4'd0,
    ST_MODRM   = 4'd1,
    ST_DISP_LO = 4'd2,
    ST_DISP_HI = 4'd3,
    ST_IMM_LO  = 4'd4,
    ST_IMM_HI  = 4'd5,
    ST_IMM2_LO = 4'd6,
    ST_IMM2_HI = 4'd7,
    ST_VALID   = 4'd8
  } dec_state_e;

  // Immediate layout classes: none, byte, word, word+word (far ptr), word+byte (ENTER)
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_B    = 3'd1,
    IMM_W    = 3'd2,
    IMM_W_W  = 3'd3,
    IMM_W_B  = 3'd4
  } imm_class_e;

  // Register index: bit 3 set selects the byte registers AL..BH, clear selects AX..DI
  typedef logic [3:0] reg_idx_t;
  localparam reg_idx_t REG_NONE = 4'd0;

  // Prefix bytes
  localparam logic [7:0] PFX_ES   = 8'h26;
  localparam logic [7:0] PFX_CS   = 8'h2E;
  localparam logic [7:0] PFX_SS   = 8'h36;
  localparam logic [7:0] PFX_DS   = 8'h3E;
  localparam logic [7:0] PFX_LOCK = 8'hF0;
  localparam logic [7:0] PFX_REPN = 8'hF2;
  localparam logic [7:0] PFX_REP  = 8'hF3;

  function automatic reg_idx_t reg_index(input logic byte_reg, input logic [2:0] num);
    return {byte_reg, num};
  endfunction

  function automatic logic is_seg_prefix(input logic [7:0] op);
    return (op == PFX_ES) || (op == PFX_CS) || (op == PFX_SS) || (op == PFX_DS);
  endfunction

  function automatic logic has_modrm(input logic [7:0] op);
    logic r;
    r = (op[7:6] == 2'b00) && !op[2];
    case (op) inside
      8'h62, 8'h63, 8'h69, 8'h6B, [8'h80:8'h8F], 8'hC0, 8'hC1, [8'hC4:8'hC7],
      [8'hD0:8'hD3], [8'hD8:8'hDF], 8'hF6, 8'hF7, 8'hFE, 8'hFF: r = 1'b1;
      default: ;
    endcase
    return r;
  endfunction

  // Immediate layout; the reg field only matters for the F6/F7 group (TEST carries an immediate)
  function automatic imm_class_e imm_bytes(input logic [7:0] op, input logic [2:0] reg_f);
    imm_class_e c;
    c = IMM_NONE;
    if ((op[7:6] == 2'b00) && (op[2:0] == 3'd4)) begin
      c = IMM_B;
    end else if ((op[7:6] == 2'b00) && (op[2:0] == 3'd5)) begin
      c = IMM_W;
    end else begin
      case (op) inside
        8'h6A, 8'h6B, 8'h80, 8'h82, 8'h83, 8'hA8, [8'hB0:8'hB7], 8'hC0, 8'hC1, 8'hC6,
        8'hCD, [8'hE4:8'hE7], 8'hEB, [8'h70:8'h7F], [8'hE0:8'hE3]: c = IMM_B;
        8'h68, 8'h69, 8'h81, 8'hA9, [8'hB8:8'hBF], 8'hC2, 8'hCA, 8'hC7, 8'hE8, 8'hE9: c = IMM_W;
        8'hF6: if (reg_f == 3'd0) c = IMM_B;
        8'hF7: if (reg_f == 3'd0) c = IMM_W;
        8'h9A, 8'hEA: c = IMM_W_W;
        8'hC8: c = IMM_W_B;
        default: ;
      endcase
    end
    return c;
  endfunction

  function automatic logic imm_sext(input logic [7:0] op);
    logic r;
    r = 1'b0;
    case (op) inside
      8'h6A, 8'h6B, 8'h83, [8'h70:8'h7F], [8'hE0:8'hE3], 8'hEB: r = 1'b1;
      default: ;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/opcode_attributes.sv
`default_nettype none
// ============================================================================
// Module   : opcode_attributes
// Brief    : Combinational opcode attribute table (ModRM presence, immediate
//            class and signedness, d/w register usage, direct displacement).
// Revision : 1.0 - initial release
// ============================================================================
module opcode_attributes
  import v30_decode_pkg::*;
(
  input  logic [7:0] op,
  input  logic [2:0] reg_f,
  output logic       modrm,
  output imm_class_e imm_cls,
  output logic       imm_signed,
  output logic       dw_group,
  output logic       disp_direct
);

  // Pure table lookup on the opcode (and reg field for the F6/F7 group)
  always_comb begin
    modrm       = has_modrm(op);
    imm_cls     = imm_bytes(op, reg_f);
    imm_signed  = imm_sext(op);
    dw_group    = ((op[7:6] == 2'b00) && !op[2]) || ((op >= 8'h84) && (op <= 8'h8B));
    disp_direct = (op[7:2] == 6'b1010_00);
  end

endmodule
`default_nettype wire

// File: rtl/instruction_decoder.sv
`default_nettype none
// ============================================================================
// Module   : instruction_decoder
// Brief    : Byte-serial x86/V30 decoder; collects prefixes, opcode, ModRM,
//            displacement and immediates, then hands one decoded instruction
//            to the microsequencer under valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_decoder
  import v30_decode_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [7:0]  fetch_data,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  output logic        decode_valid,
  input  logic        decode_ready,
  output logic [7:0]  opcode,
  output logic [1:0]  mod,
  output logic [2:0]  rm,
  output logic [2:0]  reg_field,
  output logic [3:0]  src,
  output logic [3:0]  dst,
  output logic [15:0] disp,
  output logic [15:0] imm,
  output logic        imm_size,
  output logic [15:0] imm2,
  output logic [2:0]  seg_override,
  output logic [1:0]  rep,
  output logic        lock,
  output logic [3:0]  length
);

  dec_state_e  state_q, state_d;
  logic        decode_valid_q, decode_valid_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [1:0]  mod_q, mod_d;
  logic [2:0]  rm_q, rm_d;
  logic [2:0]  reg_q, reg_d;
  reg_idx_t    src_q, src_d, dst_q, dst_d;
  logic [15:0] disp_q, disp_d, imm_q, imm_d, imm2_q, imm2_d;
  logic        imm_size_q, imm_size_d;
  logic [2:0]  seg_q, seg_d;
  logic [1:0]  rep_q, rep_d;
  logic        lock_q, lock_d;
  logic [3:0]  length_q, length_d;
  logic        disp2_q, disp2_d;

  logic        accept;
  logic [7:0]  attr_op;
  logic [2:0]  attr_reg;
  logic        attr_modrm, attr_signed, attr_dw, attr_direct;
  imm_class_e  attr_imm;
  dec_state_e  after_disp;

  // Look up the byte being decoded in OPCODE, the latched opcode afterwards;
  // the reg field comes straight off the bus while the ModRM byte is accepted
  assign attr_op  = (state_q == ST_OPCODE) ? fetch_data : opcode_q;
  assign attr_reg = (state_q == ST_MODRM) ? fetch_data[5:3] : reg_q;

  opcode_attributes u_attr (
    .op          (attr_op),
    .reg_f       (attr_reg),
    .modrm       (attr_modrm),
    .imm_cls     (attr_imm),
    .imm_signed  (attr_signed),
    .dw_group    (attr_dw),
    .disp_direct (attr_direct)
  );

  // A flush cycle never consumes a byte, so ready is gated by it as well
  assign fetch_ready = reset && !flush && (state_q != ST_VALID);
  assign accept      = fetch_valid && fetch_ready;
  assign after_disp  = (attr_imm != IMM_NONE) ? ST_IMM_LO : ST_VALID;

  // Next-state and field-collection logic for every decode register
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    mod_d      = mod_q;
    rm_d       = rm_q;
    reg_d      = reg_q;
    src_d      = src_q;
    dst_d      = dst_q;
    disp_d     = disp_q;
    imm_d      = imm_q;
    imm2_d     = imm2_q;
    imm_size_d = imm_size_q;
    seg_d      = seg_q;
    rep_d      = rep_q;
    lock_d     = lock_q;
    length_d   = length_q;
    disp2_d    = disp2_q;

    if (flush) begin
      state_d  = ST_OPCODE;
      seg_d    = 3'd0;
      rep_d    = 2'd0;
      lock_d   = 1'b0;
      length_d = 4'd0;
    end else if (state_q == ST_VALID) begin
      if (decode_ready) begin
        state_d  = ST_OPCODE;
        seg_d    = 3'd0;
        rep_d    = 2'd0;
        lock_d   = 1'b0;
        length_d = 4'd0;
      end
    end else if (accept) begin
      if (length_q != 4'hF) length_d = length_q + 4'd1;
      case (state_q)
        ST_OPCODE: begin
          if (is_seg_prefix(fetch_data)) begin
            seg_d = {1'b1, fetch_data[4:3]};
          end else if (fetch_data == PFX_LOCK) begin
            lock_d = 1'b1;
          end else if ((fetch_data == PFX_REPN) || (fetch_data == PFX_REP)) begin
            rep_d = {1'b1, fetch_data[0]};
          end else begin
            opcode_d   = fetch_data;
            mod_d      = 2'd0;
            rm_d       = 3'd0;
            reg_d      = 3'd0;
            disp_d     = 16'd0;
            imm_d      = 16'd0;
            imm2_d     = 16'd0;
            imm_size_d = 1'b0;
            disp2_d    = 1'b0;
            src_d      = REG_NONE;
            dst_d      = REG_NONE;
            if (fetch_data[7:4] == 4'hB) begin
              dst_d = reg_index(~fetch_data[3], fetch_data[2:0]);
            end else if ((fetch_data >= 8'h40) && (fetch_data <= 8'h5F)) begin
              dst_d = reg_index(1'b0, fetch_data[2:0]);
              src_d = reg_index(1'b0, fetch_data[2:0]);
            end
            if (attr_modrm) begin
              state_d = ST_MODRM;
            end else if (attr_direct) begin
              disp2_d = 1'b1;
              state_d = ST_DISP_LO;
            end else begin
              state_d = after_disp;
            end
          end
        end
        ST_MODRM: begin
          mod_d = fetch_data[7:6];
          reg_d = fetch_data[5:3];
          rm_d  = fetch_data[2:0];
          if (attr_dw && opcode_q[1]) begin
            dst_d = reg_index(~opcode_q[0], fetch_data[5:3]);
            src_d = reg_index(~opcode_q[0], fetch_data[2:0]);
          end else begin
            src_d = reg_index(~opcode_q[0], fetch_data[5:3]);
            dst_d = reg_index(~opcode_q[0], fetch_data[2:0]);
          end
          if (fetch_data[7:6] == 2'b01) begin
            disp2_d = 1'b0;
            state_d = ST_DISP_LO;
          end else if ((fetch_data[7:6] == 2'b10) ||
                       ((fetch_data[7:6] == 2'b00) && (fetch_data[2:0] == 3'b110))) begin
            disp2_d = 1'b1;
            state_d = ST_DISP_LO;
          end else begin
            state_d = after_disp;
          end
        end
        ST_DISP_LO: begin
          disp_d  = {{8{fetch_data[7]}}, fetch_data};
          state_d = disp2_q ? ST_DISP_HI : after_disp;
        end
        ST_DISP_HI: begin
          disp_d[15:8] = fetch_data;
          state_d      = after_disp;
        end
        ST_IMM_LO: begin
          imm_d      = attr_signed ? {{8{fetch_data[7]}}, fetch_data} : {8'h00, fetch_data};
          imm_size_d = 1'b0;
          state_d    = (attr_imm == IMM_B) ? ST_VALID : ST_IMM_HI;
        end
        ST_IMM_HI: begin
          imm_d[15:8] = fetch_data;
          imm_size_d  = 1'b1;
          state_d     = ((attr_imm == IMM_W_W) || (attr_imm == IMM_W_B)) ? ST_IMM2_LO : ST_VALID;
        end
        ST_IMM2_LO: begin
          imm2_d  = {8'h00, fetch_data};
          state_d = (attr_imm == IMM_W_W) ? ST_IMM2_HI : ST_VALID;
        end
        ST_IMM2_HI: begin
          imm2_d[15:8] = fetch_data;
          state_d      = ST_VALID;
        end
        default: state_d = state_q;
      endcase
    end

    decode_valid_d = (state_d == ST_VALID);
  end

  // Decoder state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_OPCODE;
      decode_valid_q <= 1'b0;
      opcode_q       <= 8'd0;
      mod_q          <= 2'd0;
      rm_q           <= 3'd0;
      reg_q          <= 3'd0;
      src_q          <= REG_NONE;
      dst_q          <= REG_NONE;
      disp_q         <= 16'd0;
      imm_q          <= 16'd0;
      imm2_q         <= 16'd0;
      imm_size_q     <= 1'b0;
      seg_q          <= 3'd0;
      rep_q          <= 2'd0;
      lock_q         <= 1'b0;
      length_q       <= 4'd0;
      disp2_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      decode_valid_q <= decode_valid_d;
      opcode_q       <= opcode_d;
      mod_q          <= mod_d;
      rm_q           <= rm_d;
      reg_q          <= reg_d;
      src_q          <= src_d;
      dst_q          <= dst_d;
      disp_q         <= disp_d;
      imm_q          <= imm_d;
      imm2_q         <= imm2_d;
      imm_size_q     <= imm_size_d;
      seg_q          <= seg_d;
      rep_q          <= rep_d;
      lock_q         <= lock_d;
      length_q       <= length_d;
      disp2_q        <= disp2_d;
    end
  end

  assign decode_valid = decode_valid_q;
  assign opcode       = opcode_q;
  assign mod          = mod_q;
  assign rm           = rm_q;
  assign reg_field    = reg_q;
  assign src          = src_q;
  assign dst          = dst_q;
  assign disp         = disp_q;
  assign imm          = imm_q;
  assign imm_size     = imm_size_q;
  assign imm2         = imm2_q;
  assign seg_override = seg_q;
  assign rep          = rep_q;
  assign lock         = lock_q;
  assign length       = length_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_decoder
// Brief    : Directed self-checking bench for instruction_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_decoder;

  logic        clk = 1'b0;
  logic        reset, flush, fetch_valid, decode_ready;
  logic [7:0]  fetch_data;
  logic        fetch_ready, decode_valid, imm_size, lock;
  logic [7:0]  opcode;
  logic [1:0]  mod, rep;
  logic [2:0]  rm, reg_field, seg_override;
  logic [3:0]  src, dst, length;
  logic [15:0] disp, imm, imm2;

  int n_vec = 0;
  int n_miscmp = 0;

  always #5 clk = ~clk;

  instruction_decoder dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .fetch_data   (fetch_data),
    .fetch_valid  (fetch_valid),
    .fetch_ready  (fetch_ready),
    .decode_valid (decode_valid),
    .decode_ready (decode_ready),
    .opcode       (opcode),
    .mod          (mod),
    .rm           (rm),
    .reg_field    (reg_field),
    .src          (src),
    .dst          (dst),
    .disp         (disp),
    .imm          (imm),
    .imm_size     (imm_size),
    .imm2         (imm2),
    .seg_override (seg_override),
    .rep          (rep),
    .lock         (lock),
    .length       (length)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one byte for exactly one clock edge; sampling point is #1 after it
  task automatic push(input logic [7:0] b);
    fetch_data  = b;
    fetch_valid = 1'b1;
    @(posedge clk); #1;
    fetch_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Hand the decoded instruction off and confirm the handshake cleared it
  task automatic take(input string tag);
    decode_ready = 1'b1;
    @(posedge clk); #1;
    decode_ready = 1'b0;
    chk({tag, ".dv_clr"}, {15'd0, decode_valid}, 16'd0);
    chk({tag, ".len_clr"}, {12'd0, length}, 16'd0);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; fetch_valid = 1'b0; fetch_data = 8'h00; decode_ready = 1'b0;
    idle(2);
    chk("rst.fetch_ready", {15'd0, fetch_ready}, 16'd0);
    chk("rst.dv",          {15'd0, decode_valid}, 16'd0);
    chk("rst.opcode",      {8'd0, opcode}, 16'd0);
    chk("rst.length",      {12'd0, length}, 16'd0);
    reset = 1'b1;
    idle(1);
    chk("rst.ready_after", {15'd0, fetch_ready}, 16'd1);

    // MOV r16, r/m16 with 16-bit displacement
    push(8'h8B); push(8'h80); push(8'h34);
    chk("t1.dv_early", {15'd0, decode_valid}, 16'd0);
    push(8'h12);
    chk("t1.dv",     {15'd0, decode_valid}, 16'd1);
    chk("t1.ready",  {15'd0, fetch_ready}, 16'd0);
    chk("t1.opcode", {8'd0, opcode}, 16'h008B);
    chk("t1.mod",    {14'd0, mod}, 16'd2);
    chk("t1.rm",     {13'd0, rm}, 16'd0);
    chk("t1.reg",    {13'd0, reg_field}, 16'd0);
    chk("t1.dst",    {12'd0, dst}, 16'd0);
    chk("t1.src",    {12'd0, src}, 16'd0);
    chk("t1.disp",   disp, 16'h1234);
    chk("t1.length", {12'd0, length}, 16'd4);
    take("t1");

    // CS: REP MOVSB
    push(8'h2E); push(8'hF3); push(8'hA4);
    chk("t2.dv",     {15'd0, decode_valid}, 16'd1);
    chk("t2.seg",    {13'd0, seg_override}, 16'h0005);
    chk("t2.rep",    {14'd0, rep}, 16'h0003);
    chk("t2.opcode", {8'd0, opcode}, 16'h00A4);
    chk("t2.length", {12'd0, length}, 16'd3);
    chk("t2.mod",    {14'd0, mod}, 16'd0);
    take("t2");
    chk("t2.seg_clr", {13'd0, seg_override}, 16'd0);
    chk("t2.rep_clr", {14'd0, rep}, 16'd0);

    // ADD word [bp-2], sign-extended imm8
    push(8'h83); push(8'h46); push(8'hFE); push(8'h05);
    chk("t3.mod",   {14'd0, mod}, 16'd1);
    chk("t3.rm",    {13'd0, rm}, 16'd6);
    chk("t3.disp",  disp, 16'hFFFE);
    chk("t3.imm",   imm, 16'h0005);
    chk("t3.isz",   {15'd0, imm_size}, 16'd0);
    chk("t3.dst",   {12'd0, dst}, 16'd6);
    take("t3");
    // ADD BX, imm16
    push(8'h81); push(8'hC3); push(8'h34); push(8'h12);
    chk("t3b.imm",  imm, 16'h1234);
    chk("t3b.isz",  {15'd0, imm_size}, 16'd1);
    chk("t3b.dst",  {12'd0, dst}, 16'd3);
    chk("t3b.disp", disp, 16'h0000);
    take("t3b");

    // TEST byte [1234], imm8
    push(8'hF6); push(8'h06); push(8'h34); push(8'h12); push(8'hAA);
    chk("t4.dv",     {15'd0, decode_valid}, 16'd1);
    chk("t4.disp",   disp, 16'h1234);
    chk("t4.imm",    imm, 16'h00AA);
    chk("t4.length", {12'd0, length}, 16'd5);
    take("t4");
    // NOT byte [1234] has no immediate
    push(8'hF6); push(8'h16); push(8'h34); push(8'h12);
    chk("t4b.dv",     {15'd0, decode_valid}, 16'd1);
    chk("t4b.length", {12'd0, length}, 16'd4);
    chk("t4b.imm",    imm, 16'h0000);
    chk("t4b.reg",    {13'd0, reg_field}, 16'd2);
    take("t4b");

    // JMP far F000:0100 with a gap after every byte
    push(8'hEA); idle(1);
    chk("t5.stall_dv", {15'd0, decode_valid}, 16'd0);
    push(8'h00); idle(1);
    push(8'h01); idle(1);
    push(8'h00); idle(1);
    chk("t5.dv_early", {15'd0, decode_valid}, 16'd0);
    push(8'hF0);
    chk("t5.dv",     {15'd0, decode_valid}, 16'd1);
    chk("t5.imm",    imm, 16'h0100);
    chk("t5.imm2",   imm2, 16'hF000);
    chk("t5.length", {12'd0, length}, 16'd5);
    idle(3);
    chk("t5.hold_dv",  {15'd0, decode_valid}, 16'd1);
    chk("t5.hold_imm", imm2, 16'hF000);
    take("t5");

    // ENTER 0010, 02: word immediate plus byte level
    push(8'hC8); push(8'h10); push(8'h00); push(8'h02);
    chk("t6.imm",    imm, 16'h0010);
    chk("t6.imm2",   imm2, 16'h0002);
    chk("t6.length", {12'd0, length}, 16'd4);
    take("t6");

    // LOCK PUSH imm8 sign-extended
    push(8'hF0); push(8'h6A); push(8'hFF);
    chk("t7.lock", {15'd0, lock}, 16'd1);
    chk("t7.imm",  imm, 16'hFFFF);
    chk("t7.len",  {12'd0, length}, 16'd3);
    take("t7");
    chk("t7.lock_clr", {15'd0, lock}, 16'd0);

    // INC BX: one-byte instruction, register in opcode
    push(8'h43);
    chk("t8.dv",  {15'd0, decode_valid}, 16'd1);
    chk("t8.dst", {12'd0, dst}, 16'd3);
    chk("t8.src", {12'd0, src}, 16'd3);
    take("t8");

    // Flush mid-instruction, then decode MOV AX, imm16 cleanly
    push(8'h3E); push(8'hC7); push(8'h06);
    flush = 1'b1; fetch_valid = 1'b1; fetch_data = 8'hB8;
    #1;
    chk("t9.flush_ready", {15'd0, fetch_ready}, 16'd0);
    @(posedge clk); #1;
    flush = 1'b0; fetch_valid = 1'b0;
    chk("t9.dv",  {15'd0, decode_valid}, 16'd0);
    chk("t9.seg", {13'd0, seg_override}, 16'd0);
    chk("t9.len", {12'd0, length}, 16'd0);
    push(8'hB8); push(8'h34); push(8'h12);
    chk("t9b.dv",     {15'd0, decode_valid}, 16'd1);
    chk("t9b.opcode", {8'd0, opcode}, 16'h00B8);
    chk("t9b.dst",    {12'd0, dst}, 16'd0);
    chk("t9b.imm",    imm, 16'h1234);
    chk("t9b.len",    {12'd0, length}, 16'd3);
    take("t9b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
`default_nettype wire
